// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if
//   Bundles the operand sequencer's SRAM read ports and its MAC feed.
//   master : the sequencer (drives read enables/addresses and the MAC operands)
//   slave  : the SRAM/MAC side (returns read data, consumes the MAC operands)
//   Signals:
//     if_rd_en/if_rd_addr/if_rd_data  ifmap SRAM read port (data one cycle after enable)
//     w_rd_en/w_rd_addr/w_rd_data     weight SRAM read port (data one cycle after enable)
//     mac_ifmap/mac_weights           operands presented to the MAC
//     mac_en/mac_lastdata             MAC accumulate enable and final-pair flag
interface mac_operand_sequencer_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
);
   logic              if_rd_en;
   logic [ADDR_W-1:0] if_rd_addr;
   logic [DATA_W-1:0] if_rd_data;
   logic              w_rd_en;
   logic [ADDR_W-1:0] w_rd_addr;
   logic [DATA_W-1:0] w_rd_data;
   logic [DATA_W-1:0] mac_ifmap;
   logic [DATA_W-1:0] mac_weights;
   logic              mac_en;
   logic              mac_lastdata;

   modport master (
      output if_rd_en, if_rd_addr, w_rd_en, w_rd_addr,
      input  if_rd_data, w_rd_data,
      output mac_ifmap, mac_weights, mac_en, mac_lastdata
   );

   modport slave (
      input  if_rd_en, if_rd_addr, w_rd_en, w_rd_addr,
      output if_rd_data, w_rd_data,
      input  mac_ifmap, mac_weights, mac_en, mac_lastdata
   );
endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
//   Feeds a 32-bit MAC with one dot product per start command. Reads vec_len
//   element pairs from the ifmap and weight SRAMs (1-cycle synchronous reads) and
//   forwards the returned data to the MAC with en/lastdata, then pulses done once
//   the MAC accumulation holds the result.
//   Ports:
//     clk, reset        clock and synchronous active-high reset
//     start             command strobe, only looked at while idle
//     if_base, w_base   first ifmap/weight addresses (wrap modulo 2**ADDR_W)
//     vec_len           number of element pairs, 0 = no-op command
//     hold              stall: no new read is issued this cycle
//     busy, done        status; done is a one-cycle pulse
//     bus               SRAM read ports and MAC feed (master side)
module mac_operand_sequencer #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10,
   parameter int LEN_W  = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] if_base,
   input  logic [ADDR_W-1:0] w_base,
   input  logic [LEN_W-1:0]  vec_len,
   input  logic              hold,
   output logic              busy,
   output logic              done,
   mac_operand_sequencer_if.master bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t            state;
   state_t            stateNext;
   logic [LEN_W-1:0]  idx;
   logic [LEN_W-1:0]  lenQ;
   logic [ADDR_W-1:0] ifBaseQ;
   logic [ADDR_W-1:0] wBaseQ;
   logic              rdEn;
   logic              isLast;
   logic              macEn;
   logic              macLast;

   assign isLast = (idx == (lenQ - LEN_W'(1)));

   // State register plus the command latches, read index and the registered
   // MAC controls. mac_en is simply the previous cycle's read enable, which lines
   // it up with the SRAM data; lastdata follows the read tagged as final.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         idx     <= '0;
         lenQ    <= '0;
         ifBaseQ <= '0;
         wBaseQ  <= '0;
         macEn   <= 1'b0;
         macLast <= 1'b0;
      end else begin
         state   <= stateNext;
         macEn   <= rdEn;
         macLast <= rdEn && isLast;
         if (state == IDLE && start && vec_len != '0) begin
            ifBaseQ <= if_base;
            wBaseQ  <= w_base;
            lenQ    <= vec_len;
            idx     <= '0;
         end else if (rdEn) begin
            idx <= idx + LEN_W'(1);
         end
      end
   end

   // Next-state and read issue. A zero-length command still passes through
   // DRAIN (with nothing in flight) so that done always lands N+2 cycles after
   // start is sampled, including N=0.
   always_comb begin
      stateNext = state;
      rdEn      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               stateNext = (vec_len != '0) ? ISSUE : DRAIN;
            end
         end
         ISSUE: begin
            if (!hold) begin
               rdEn = 1'b1;
               if (isLast) begin
                  stateNext = DRAIN;
               end
            end
         end
         DRAIN: begin
            stateNext = DONE;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // Addresses are base+idx and wrap silently; during a hold idx is frozen so
   // the address stays put until the read is actually issued.
   assign bus.if_rd_en     = rdEn;
   assign bus.w_rd_en      = rdEn;
   assign bus.if_rd_addr   = ifBaseQ + ADDR_W'(idx);
   assign bus.w_rd_addr    = wBaseQ + ADDR_W'(idx);
   assign bus.mac_en       = macEn;
   assign bus.mac_lastdata = macLast;
   assign bus.mac_ifmap    = macEn ? bus.if_rd_data : '0;
   assign bus.mac_weights  = macEn ? bus.w_rd_data : '0;

   assign busy = (state != IDLE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer
//   Directed bench for mac_operand_sequencer. Models both SRAMs and a 32-bit MAC
//   that restarts its accumulation after each lastdata. Expected read addresses
//   and operand pairs are queued when a command is driven and checked as the
//   DUT issues reads and MAC enables.
module tb_mac_operand_sequencer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;
   localparam int LEN_W  = 10;

   typedef struct {
      logic [DATA_W-1:0] ifv;
      logic [DATA_W-1:0] wv;
      logic              last;
   } op_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [ADDR_W-1:0] if_base;
   logic [ADDR_W-1:0] w_base;
   logic [LEN_W-1:0]  vec_len;
   logic              hold;
   logic              busy;
   logic              done;

   logic [DATA_W-1:0] ifMem [1024];
   logic [DATA_W-1:0] wMem [1024];
   logic [DATA_W-1:0] macAcc;
   logic              macClear;
   logic              monitorOn = 1'b0;

   logic [ADDR_W-1:0] ifAddrQ [$];
   logic [ADDR_W-1:0] wAddrQ [$];
   op_t               opQ [$];

   int testsRun    = 0;
   int testsFailed = 0;

   mac_operand_sequencer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   mac_operand_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .if_base (if_base),
      .w_base  (w_base),
      .vec_len (vec_len),
      .hold    (hold),
      .busy    (busy),
      .done    (done),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   // SRAM models: one-cycle synchronous reads
   initial begin
      bus.if_rd_data = '0;
      bus.w_rd_data  = '0;
   end

   always @(posedge clk) begin
      if (bus.if_rd_en) bus.if_rd_data <= ifMem[bus.if_rd_addr];
      if (bus.w_rd_en)  bus.w_rd_data  <= wMem[bus.w_rd_addr];
   end

   // MAC model: accumulates on en, starts fresh after a lastdata pair
   always @(posedge clk) begin
      if (reset) begin
         macAcc   <= '0;
         macClear <= 1'b0;
      end else if (bus.mac_en) begin
         macAcc   <= (macClear ? '0 : macAcc) + bus.mac_ifmap * bus.mac_weights;
         macClear <= bus.mac_lastdata;
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Scoreboard side: reads and MAC operands compared against queued expectations
   always @(negedge clk) begin
      if (monitorOn) begin
         if (bus.if_rd_en === 1'b1) begin
            checkOutput("readExpected", 32'(ifAddrQ.size() != 0), 1);
            checkOutput("wRdEnHigh", 32'(bus.w_rd_en), 1);
            if (ifAddrQ.size() != 0) begin
               checkOutput("ifRdAddr", 32'(bus.if_rd_addr), 32'(ifAddrQ.pop_front()));
               checkOutput("wRdAddr", 32'(bus.w_rd_addr), 32'(wAddrQ.pop_front()));
            end
         end else begin
            checkOutput("wRdEnLow", 32'(bus.w_rd_en), 0);
         end
         if (bus.mac_en === 1'b1) begin
            checkOutput("macExpected", 32'(opQ.size() != 0), 1);
            if (opQ.size() != 0) begin
               op_t op;
               op = opQ.pop_front();
               checkOutput("macIfmap", bus.mac_ifmap, op.ifv);
               checkOutput("macWeights", bus.mac_weights, op.wv);
               checkOutput("macLast", 32'(bus.mac_lastdata), 32'(op.last));
            end
         end else begin
            checkOutput("macLastIdle", 32'(bus.mac_lastdata), 0);
            checkOutput("macIfmapIdle", bus.mac_ifmap, 0);
         end
      end
   end

   // Runs one command. Cycle 0 is the cycle start is sampled in; holdMask bit c
   // drives hold during cycle c; startPulse re-asserts start in that cycle.
   task automatic applyStimulus(input logic [ADDR_W-1:0] ifb, input logic [ADDR_W-1:0] wb,
                                input logic [LEN_W-1:0] len, input logic [31:0] holdMask,
                                input int startPulse, input int expDone);
      logic [DATA_W-1:0] expAcc;
      logic [ADDR_W-1:0] a;
      logic [ADDR_W-1:0] b;
      op_t               op;
      int                doneSeen;
      int                doneCycle;
      @(posedge clk); #1;
      if_base = ifb;
      w_base  = wb;
      vec_len = len;
      start   = 1'b1;
      hold    = 1'b0;
      expAcc  = (len == 0) ? macAcc : '0;
      for (int k = 0; k < int'(len); k++) begin
         a = ifb + ADDR_W'(k);
         b = wb + ADDR_W'(k);
         ifAddrQ.push_back(a);
         wAddrQ.push_back(b);
         op.ifv  = ifMem[a];
         op.wv   = wMem[b];
         op.last = (k == int'(len) - 1);
         opQ.push_back(op);
         expAcc = expAcc + ifMem[a] * wMem[b];
      end
      @(negedge clk);
      checkOutput("idleBusy", 32'(busy), 0);
      checkOutput("idleDone", 32'(done), 0);
      @(posedge clk); #1;
      start   = 1'b0;
      if_base = ADDR_W'($urandom);
      w_base  = ADDR_W'($urandom);
      vec_len = LEN_W'($urandom_range(1, 5));
      doneSeen  = 0;
      doneCycle = -1;
      for (int c = 1; c <= expDone; c++) begin
         hold  = holdMask[c];
         start = (c == startPulse);
         @(negedge clk);
         checkOutput("busy", 32'(busy), 1);
         if (done) begin
            doneSeen++;
            doneCycle = c;
            checkOutput("accAtDone", macAcc, expAcc);
         end
         if (c < expDone) begin
            @(posedge clk); #1;
         end
      end
      hold  = 1'b0;
      start = 1'b0;
      checkOutput("doneCycle", 32'(doneCycle), 32'(expDone));
      checkOutput("doneCount", 32'(doneSeen), 1);
      checkOutput("readsLeft", 32'(ifAddrQ.size()), 0);
      checkOutput("opsLeft", 32'(opQ.size()), 0);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      hold    = 1'b0;
      if_base = '0;
      w_base  = '0;
      vec_len = '0;
      for (int i = 0; i < 1024; i++) begin
         ifMem[i] = DATA_W'($urandom);
         wMem[i]  = DATA_W'($urandom);
      end
      for (int i = 0; i < 4; i++) begin
         ifMem[i] = DATA_W'(i + 1);
         wMem[i]  = DATA_W'(i + 5);
      end

      // reset state
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("rstBusy", 32'(busy), 0);
      checkOutput("rstDone", 32'(done), 0);
      checkOutput("rstRdEn", 32'(bus.if_rd_en), 0);
      checkOutput("rstMacEn", 32'(bus.mac_en), 0);
      checkOutput("rstLast", 32'(bus.mac_lastdata), 0);
      checkOutput("rstIfAddr", 32'(bus.if_rd_addr), 0);
      checkOutput("rstWAddr", 32'(bus.w_rd_addr), 0);
      checkOutput("rstIfmap", bus.mac_ifmap, 0);
      @(posedge clk); #1;
      reset     = 1'b0;
      monitorOn = 1'b1;

      // basic N=4 dot product
      applyStimulus(10'd0, 10'd0, 10'd4, 32'h0, -1, 6);
      checkOutput("acc70", macAcc, 70);

      // hold in cycles 2 and 3
      applyStimulus(10'd0, 10'd0, 10'd4, 32'h0000_000C, -1, 8);
      checkOutput("acc70Hold", macAcc, 70);

      // zero-length command leaves the accumulation alone
      applyStimulus(10'd0, 10'd0, 10'd0, 32'h0, -1, 2);
      checkOutput("accKept", macAcc, 70);

      // address wrap
      applyStimulus(10'd1022, 10'd1020, 10'd4, 32'h0, -1, 6);

      // start while busy is ignored; the next start right after DONE is taken
      applyStimulus(10'd0, 10'd0, 10'd4, 32'h0, 3, 6);
      applyStimulus(10'd0, 10'd0, 10'd4, 32'h0, -1, 6);
      checkOutput("accAfterIgnored", macAcc, 70);

      // reset in cycle 3 of an N=8 command
      @(posedge clk); #1;
      if_base = 10'd100;
      w_base  = 10'd200;
      vec_len = 10'd8;
      start   = 1'b1;
      for (int k = 0; k < 8; k++) begin
         op_t op;
         ifAddrQ.push_back(ADDR_W'(100 + k));
         wAddrQ.push_back(ADDR_W'(200 + k));
         op.ifv  = ifMem[100 + k];
         op.wv   = wMem[200 + k];
         op.last = (k == 7);
         opQ.push_back(op);
      end
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checkOutput("readsBeforeAbort", 32'(ifAddrQ.size()), 5);
      ifAddrQ.delete();
      wAddrQ.delete();
      opQ.delete();
      @(negedge clk);
      checkOutput("abortBusy", 32'(busy), 0);
      checkOutput("abortRdEn", 32'(bus.if_rd_en), 0);
      checkOutput("abortMacEn", 32'(bus.mac_en), 0);
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         @(negedge clk);
         checkOutput("abortNoDone", 32'(done), 0);
         checkOutput("abortIdle", 32'(busy), 0);
      end

      // fresh command after the abort
      applyStimulus(10'd0, 10'd0, 10'd4, 32'h0, -1, 6);
      checkOutput("accAfterAbort", macAcc, 70);

      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
